display_source_scheduler: RTL and testbench
===========================================

Name: display_source_scheduler

Overview:
- Shares the two-digit 7-segment display between several 8-bit sample sources, e.g. the X/Y/Z accelerometer axes from the SPI reader.
- Rotates round-robin among sources with valid data, showing each for a fixed dwell time.
- Supports hold and manual-advance controls.
- Drives the display block's DATA_IN and reports which source is shown.

Parameters:
- NUM_SRC, 3, number of sources (2..4).
- DWELL_CYCLES, 100_000_000, CLK cycles each source is shown (>=2).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- SRC_DATA  in  NUM_SRC*8  packed samples; source i occupies bits [8i+7:8i], two's complement.
- SRC_VALID  in  NUM_SRC  source i presents a new sample this cycle.
- SRC_ACK  out  NUM_SRC  one-cycle pulse: sample of source i was latched.
- HOLD  in  1  level; freeze on the current source.
- NEXT  in  1  single-cycle pulse; advance immediately.
- DISP_DATA  out  8  value to the display's DATA_IN.
- DISP_SEL  out  2  index of the source shown.
- DISP_STALE  out  1  the last scan found no valid source.

Behaviour:
- Reset (async, immediate): DISP_DATA=0, DISP_SEL=0, DISP_STALE=0, SRC_ACK=0, dwell counter=0, state IDLE.
- Dwell counter width is $clog2(DWELL_CYCLES). It counts 0..DWELL_CYCLES-1 in SHOW only.
- States: IDLE, SCAN, SHOW.
- IDLE:
  - When any SRC_VALID is high, enter SCAN.
  - The first scan starts at candidate 0 inclusive.
- SCAN:
  - Checks one candidate per cycle, round-robin starting at DISP_SEL+1 (mod NUM_SRC); DISP_SEL itself is checked last.
  - On the first candidate c with SRC_VALID[c]=1, at the next edge: DISP_DATA<=sample c, DISP_SEL<=c, SRC_ACK[c]=1 for one cycle, DISP_STALE<=0, counter<=0, state SHOW.
  - Latency: candidate k positions after DISP_SEL is latched k cycles after SCAN entry (one candidate per cycle).
  - If no candidate is valid after NUM_SRC cycles: enter SHOW with DISP_SEL and DISP_DATA unchanged, DISP_STALE<=1, counter<=0.
- SHOW:
  - If SRC_VALID[DISP_SEL]=1: refresh DISP_DATA, pulse SRC_ACK[DISP_SEL], clear DISP_STALE. The counter is not reset.
  - Counter at DWELL_CYCLES-1 with HOLD=0: enter SCAN.
  - Counter at DWELL_CYCLES-1 with HOLD=1: counter wraps to 0 and stays in SHOW.
  - NEXT=1: enter SCAN at the next edge regardless of HOLD or counter value.
- Simultaneous events:
  - A refresh and dwell expiry (or NEXT) in the same cycle: the sample is latched and acked, then SCAN.
  - NEXT coinciding with expiry causes a single SCAN.
  - NEXT in IDLE or SCAN is ignored. HOLD is ignored outside SHOW.
- At most one SRC_ACK bit is high per cycle. SRC_VALID of non-selected sources is never acked outside SCAN.
- Reset asserted mid-scan or mid-dwell aborts with no ACK. After release, the block starts in IDLE.
- DISP_DATA passes through unmodified; sign and BCD handling stay in the display block.

Optional Feature:
- Macro: DISP_STALE_BLANK_EN.
- Defined: while DISP_STALE=1, DISP_DATA reads 8'h00, and the held sample is restored only by a new latch.
- Undefined: DISP_DATA keeps the last latched sample while stale.

Test Plan:
(NUM_SRC=3, DWELL_CYCLES=8)
1. Reset with all SRC_VALID low for 20 cycles -> DISP_DATA=00, DISP_SEL=0, DISP_STALE=0, SRC_ACK never high.
2. All valid, data 05/FB/63 held -> SEL 0 shows 05 with ACK[0]; after 8 SHOW cycles, SEL 1 shows FB; then SEL 2 shows 63; then wraps to SEL 0.
3. HOLD=1 while SEL=1 for 40 cycles -> SEL stays 1. A NEXT pulse then gives SEL=2 within 2 cycles, even with HOLD still high.
4. Only src2 valid and shown; all valid dropped -> at expiry, 3 scan cycles, then SEL=2, DISP_STALE=1, DISP_DATA held (00 with DISP_STALE_BLANK_EN). Asserting valid[0]=7F then gives SEL=0, DATA=7F, STALE=0 at the next scan.
5. src0 shown; valid[0] pulsed with data 12 at counter=3 -> DISP_DATA=12 next cycle, ACK[0] pulses, expiry still occurs at counter=7.
6. RESET_N low mid-SCAN (between edges) -> all outputs 0 immediately, no ACK; after release, state is IDLE.

Source files
------------

// File: rtl/display_source_scheduler_if.sv
// rtl/display_source_scheduler_if.sv - source/display bus shared by the scheduler and its neighbours
// The master side presents samples and controls; the slave side is the scheduler.
interface display_source_scheduler_if #(
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC*8-1:0] SRC_DATA;
    logic [NUM_SRC-1:0]   SRC_VALID;
    logic [NUM_SRC-1:0]   SRC_ACK;
    logic                 HOLD;
    logic                 NEXT;
    logic [7:0]           DISP_DATA;
    logic [1:0]           DISP_SEL;
    logic                 DISP_STALE;

    modport master (
        output SRC_DATA, SRC_VALID, HOLD, NEXT,
        input  SRC_ACK, DISP_DATA, DISP_SEL, DISP_STALE
    );

    modport slave (
        input  SRC_DATA, SRC_VALID, HOLD, NEXT,
        output SRC_ACK, DISP_DATA, DISP_SEL, DISP_STALE
    );
endinterface

// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - round-robin dwell scheduler sharing the 7-segment display
// Optional DISP_STALE_BLANK_EN: blank DISP_DATA to 8'h00 while the display is stale.
module display_source_scheduler #(
    parameter int NUM_SRC      = 3,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    display_source_scheduler_if.slave   bus
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] LAST   = CW'(DWELL_CYCLES - 1);
    localparam logic [SW-1:0] MAXIDX = SW'(NUM_SRC - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [SW-1:0]      r_cand;
    logic [SW-1:0]      r_scan_cnt;
    logic [SW-1:0]      r_sel;
    logic [7:0]         r_data;
    logic               r_stale;
    logic [NUM_SRC-1:0] r_ack;
    logic [CW-1:0]      r_cnt;

    logic [SW-1:0]      w_idx;
    logic [7:0]         w_sample;
    logic               w_latch;
    logic               w_refresh;
    logic               w_scan_fail;
    logic               w_wrap;

    function automatic logic [SW-1:0] f_inc(input logic [SW-1:0] v);
        return (v == MAXIDX) ? '0 : v + SW'(1);
    endfunction

    // SCAN samples the candidate under test; SHOW refreshes the displayed source.
    assign w_idx    = (r_state == SCAN) ? r_cand : r_sel;
    assign w_sample = bus.SRC_DATA[{w_idx, 3'b000} +: 8];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_latch     = 1'b0;
        w_refresh   = 1'b0;
        w_scan_fail = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.SRC_VALID) w_state_nx = SCAN;
            end
            SCAN: begin
                if (bus.SRC_VALID[r_cand]) begin
                    w_latch    = 1'b1;
                    w_state_nx = SHOW;
                end else if (r_scan_cnt == MAXIDX) begin
                    w_scan_fail = 1'b1;
                    w_state_nx  = SHOW;
                end
            end
            SHOW: begin
                w_refresh = bus.SRC_VALID[r_sel];
                if (bus.NEXT || (r_cnt == LAST && !bus.HOLD)) begin
                    w_state_nx = SCAN;
                end else if (r_cnt == LAST) begin
                    w_wrap = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cand     <= '0;
            r_scan_cnt <= '0;
            r_sel      <= '0;
            r_data     <= '0;
            r_stale    <= 1'b0;
            r_ack      <= '0;
            r_cnt      <= '0;
        end else begin
            r_ack <= (w_latch || w_refresh) ? (NUM_SRC'(1) << w_idx) : '0;
            if (w_latch || w_refresh) begin
                r_data  <= w_sample;
                r_stale <= 1'b0;
            end
            if (w_latch)     r_sel   <= r_cand;
            if (w_scan_fail) r_stale <= 1'b1;
            // r_cand is preloaded so a scan begins at the right candidate on entry.
            case (r_state)
                IDLE: begin
                    r_cand     <= '0;
                    r_scan_cnt <= '0;
                    r_cnt      <= '0;
                end
                SCAN: begin
                    r_cand     <= f_inc(r_cand);
                    r_scan_cnt <= r_scan_cnt + SW'(1);
                    r_cnt      <= '0;
                end
                SHOW: begin
                    r_cand     <= f_inc(r_sel);
                    r_scan_cnt <= '0;
                    r_cnt      <= (w_wrap || w_state_nx != SHOW) ? '0 : r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.SRC_ACK    = r_ack;
    assign bus.DISP_SEL   = 2'(r_sel);
    assign bus.DISP_STALE = r_stale;
`ifdef DISP_STALE_BLANK_EN
    assign bus.DISP_DATA  = r_stale ? 8'h00 : r_data;
`else
    assign bus.DISP_DATA  = r_data;
`endif
endmodule

// File: tb/tb_display_source_scheduler.sv
// tb/tb_display_source_scheduler.sv - directed self-checking bench for display_source_scheduler
module tb_display_source_scheduler;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    display_source_scheduler_if #(.NUM_SRC(3)) ifc ();

    display_source_scheduler #(.NUM_SRC(3), .DWELL_CYCLES(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (ifc.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef DISP_STALE_BLANK_EN
    localparam logic [7:0] STALE_63 = 8'h00;
    localparam logic [7:0] STALE_12 = 8'h00;
`else
    localparam logic [7:0] STALE_63 = 8'h63;
    localparam logic [7:0] STALE_12 = 8'h12;
`endif

    initial begin
        ifc.SRC_DATA  = '0;
        ifc.SRC_VALID = '0;
        ifc.HOLD      = 1'b0;
        ifc.NEXT      = 1'b0;

        // Reset and idle with nothing valid
        repeat (2) tick();
        RESET_N = 1'b1;
        chk("rst_data", ifc.DISP_DATA, 8'h00);
        chk("rst_sel", ifc.DISP_SEL, 2'd0);
        chk("rst_stale", ifc.DISP_STALE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ack", ifc.SRC_ACK, 3'b000);
        end
        chk("idle_data", ifc.DISP_DATA, 8'h00);
        chk("idle_sel", ifc.DISP_SEL, 2'd0);
        chk("idle_stale", ifc.DISP_STALE, 1'b0);

        // Round-robin with all sources valid
        ifc.SRC_DATA  = 24'h63FB05;
        ifc.SRC_VALID = 3'b111;
        tick();
        chk("rr_scan_noack", ifc.SRC_ACK, 3'b000);
        tick();
        chk("rr0_sel", ifc.DISP_SEL, 2'd0);
        chk("rr0_data", ifc.DISP_DATA, 8'h05);
        chk("rr0_ack", ifc.SRC_ACK, 3'b001);
        repeat (8) tick();
        chk("rr0_dwell_sel", ifc.DISP_SEL, 2'd0);
        tick();
        chk("rr1_sel", ifc.DISP_SEL, 2'd1);
        chk("rr1_data", ifc.DISP_DATA, 8'hFB);
        chk("rr1_ack", ifc.SRC_ACK, 3'b010);
        repeat (8) tick();
        chk("rr1_dwell_sel", ifc.DISP_SEL, 2'd1);
        tick();
        chk("rr2_sel", ifc.DISP_SEL, 2'd2);
        chk("rr2_data", ifc.DISP_DATA, 8'h63);
        chk("rr2_ack", ifc.SRC_ACK, 3'b100);
        repeat (9) tick();
        chk("rrwrap_sel", ifc.DISP_SEL, 2'd0);
        chk("rrwrap_data", ifc.DISP_DATA, 8'h05);

        // HOLD on source 1, then NEXT overrides HOLD
        repeat (9) tick();
        chk("hold_start_sel", ifc.DISP_SEL, 2'd1);
        ifc.HOLD = 1'b1;
        repeat (20) tick();
        chk("hold20_sel", ifc.DISP_SEL, 2'd1);
        repeat (20) tick();
        chk("hold40_sel", ifc.DISP_SEL, 2'd1);
        ifc.NEXT = 1'b1;
        tick();
        ifc.NEXT = 1'b0;
        chk("next_scan_sel", ifc.DISP_SEL, 2'd1);
        tick();
        chk("next_sel", ifc.DISP_SEL, 2'd2);
        chk("next_data", ifc.DISP_DATA, 8'h63);
        ifc.HOLD = 1'b0;

        // Source 2 alone, then everything drops: stale after expiry plus 3 scan cycles
        ifc.SRC_VALID = 3'b100;
        tick();
        chk("only2_ack", ifc.SRC_ACK, 3'b100);
        repeat (2) tick();
        ifc.SRC_VALID = 3'b000;
        repeat (7) tick();
        chk("prestale", ifc.DISP_STALE, 1'b0);
        tick();
        chk("stale_flag", ifc.DISP_STALE, 1'b1);
        chk("stale_sel", ifc.DISP_SEL, 2'd2);
        chk("stale_data", ifc.DISP_DATA, STALE_63);
        chk("stale_ack", ifc.SRC_ACK, 3'b000);
        ifc.SRC_DATA  = 24'h63FB7F;
        ifc.SRC_VALID = 3'b001;
        repeat (8) tick();
        chk("stale_hold", ifc.DISP_STALE, 1'b1);
        tick();
        chk("recover_sel", ifc.DISP_SEL, 2'd0);
        chk("recover_data", ifc.DISP_DATA, 8'h7F);
        chk("recover_stale", ifc.DISP_STALE, 1'b0);
        chk("recover_ack", ifc.SRC_ACK, 3'b001);

        // Mid-dwell refresh does not restart the dwell counter
        ifc.SRC_VALID = 3'b000;
        repeat (3) tick();
        ifc.SRC_DATA  = 24'h63FB12;
        ifc.SRC_VALID = 3'b001;
        tick();
        ifc.SRC_VALID = 3'b000;
        chk("refresh_data", ifc.DISP_DATA, 8'h12);
        chk("refresh_ack", ifc.SRC_ACK, 3'b001);
        tick();
        chk("refresh_ack_clr", ifc.SRC_ACK, 3'b000);
        repeat (5) tick();
        chk("refresh_prestale", ifc.DISP_STALE, 1'b0);
        tick();
        chk("refresh_expiry", ifc.DISP_STALE, 1'b1);
        chk("refresh_exp_sel", ifc.DISP_SEL, 2'd0);
        chk("refresh_exp_data", ifc.DISP_DATA, STALE_12);

        // Reset asserted mid-SCAN, then restart from IDLE
        ifc.NEXT = 1'b1;
        tick();
        ifc.NEXT = 1'b0;
        ifc.SRC_DATA  = 24'h00AB00;
        ifc.SRC_VALID = 3'b010;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_data", ifc.DISP_DATA, 8'h00);
        chk("arst_sel", ifc.DISP_SEL, 2'd0);
        chk("arst_stale", ifc.DISP_STALE, 1'b0);
        chk("arst_ack", ifc.SRC_ACK, 3'b000);
        tick();
        chk("arst_hold_ack", ifc.SRC_ACK, 3'b000);
        tick();
        RESET_N = 1'b1;
        ifc.SRC_VALID = 3'b000;
        repeat (3) tick();
        chk("post_sel", ifc.DISP_SEL, 2'd0);
        chk("post_stale", ifc.DISP_STALE, 1'b0);
        chk("post_ack", ifc.SRC_ACK, 3'b000);
        ifc.SRC_VALID = 3'b010;
        repeat (2) tick();
        chk("post_scan_sel", ifc.DISP_SEL, 2'd0);
        chk("post_scan_ack", ifc.SRC_ACK, 3'b000);
        tick();
        chk("post_latch_sel", ifc.DISP_SEL, 2'd1);
        chk("post_latch_data", ifc.DISP_DATA, 8'hAB);
        chk("post_latch_ack", ifc.SRC_ACK, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
